fabric_instr_dispatcher: RTL and testbench

// Host-side initiator for the fabric row interface: accepts a valid/ready stream of instruction

---
 rtl/fabric_instr_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_fabric_instr_dispatcher.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_instr_dispatcher.sv
// Fabric row initiator: streams instruction words to rows, calls the touched rows, waits on ret.
// Optional WAIT-phase timeout enabled by defining FABRIC_DISPATCH_TIMEOUT_EN.
module fabric_instr_dispatcher #(
  parameter int ROWS             = 1,
  parameter int INSTR_ADDR_WIDTH = 6,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int TIMEOUT_CYCLES   = 4096,
  localparam int ROW_W           = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ROW_W-1:0]                 cmd_row,
  input  logic [INSTR_HOPS_WIDTH-1:0]      cmd_hops,
  input  logic [INSTR_ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [INSTR_DATA_WIDTH-1:0]      cmd_data,
  input  logic                             cmd_last,
  output logic [ROWS*INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [ROWS*INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [ROWS*INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic [ROWS-1:0]                  instr_en_out,
  output logic [ROWS-1:0]                  call,
  input  logic [ROWS-1:0]                  ret,
  output logic                             done_valid,
  output logic                             done_err,
  output logic                             busy
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_CALL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [ROWS-1:0]             mask_q, mask_d;
  logic [ROWS-1:0]             seen_q, seen_d;
  logic                        err_q, err_d;
  logic [ROWS-1:0]             en_q, en_d;
  logic [ROWS-1:0]             call_q, call_d;
  logic [INSTR_DATA_WIDTH-1:0] data_q [ROWS];
  logic [INSTR_DATA_WIDTH-1:0] data_d [ROWS];
  logic [INSTR_ADDR_WIDTH-1:0] addr_q [ROWS];
  logic [INSTR_ADDR_WIDTH-1:0] addr_d [ROWS];
  logic [INSTR_HOPS_WIDTH-1:0] hops_q [ROWS];
  logic [INSTR_HOPS_WIDTH-1:0] hops_d [ROWS];
  logic                        row_hit;
  logic                        wait_exit;

`ifdef FABRIC_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign cmd_ready  = (state_q == S_LOAD);
  assign busy       = (state_q != S_LOAD);
  assign done_valid = (state_q == S_DONE);
  assign done_err   = (state_q == S_DONE) & err_q;
  assign instr_en_out = en_q;
  assign call         = call_q;
  // Every row must have been seen busy at least once and be idle again.
  assign wait_exit  = (seen_q == mask_q) && ((ret & mask_q) == mask_q);

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      instr_data_out[r*INSTR_DATA_WIDTH +: INSTR_DATA_WIDTH] = data_q[r];
      instr_addr_out[r*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH] = addr_q[r];
      instr_hops_out[r*INSTR_HOPS_WIDTH +: INSTR_HOPS_WIDTH] = hops_q[r];
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    seen_d  = seen_q;
    err_d   = err_q;
    en_d    = '0;
    call_d  = '0;
    data_d  = data_q;
    addr_d  = addr_q;
    hops_d  = hops_q;
    row_hit = 1'b0;
`ifdef FABRIC_DISPATCH_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (cmd_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            if (32'(cmd_row) == r) begin
              row_hit   = 1'b1;
              en_d[r]   = 1'b1;
              mask_d[r] = 1'b1;
              data_d[r] = cmd_data;
              addr_d[r] = cmd_addr;
              hops_d[r] = cmd_hops;
            end
          end
          if (!row_hit) err_d = 1'b1;
          if (cmd_last) begin
            if (mask_d == '0) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_CALL;
            end
          end
        end
      end
      S_CALL: begin
        call_d  = mask_q;
        seen_d  = seen_q | (mask_q & ~ret);
        state_d = S_WAIT;
`ifdef FABRIC_DISPATCH_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        seen_d = seen_q | (mask_q & ~ret);
        if (wait_exit) begin
          state_d = S_DONE;
        end
`ifdef FABRIC_DISPATCH_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: begin
        mask_d  = '0;
        seen_d  = '0;
        err_d   = 1'b0;
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      mask_q  <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= '0;
      call_q  <= '0;
      for (int r = 0; r < ROWS; r++) begin
        data_q[r] <= '0;
        addr_q[r] <= '0;
        hops_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      en_q    <= en_d;
      call_q  <= call_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      hops_q  <= hops_d;
    end
  end

`ifdef FABRIC_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_fabric_instr_dispatcher.sv
// Directed bench for fabric_instr_dispatcher with three rows.
module tb_fabric_instr_dispatcher;

  localparam int ROWS = 3;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int HW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_row;
  logic [HW-1:0]    cmd_hops;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_data;
  logic             cmd_last;
  logic [ROWS*DW-1:0] instr_data_out;
  logic [ROWS*AW-1:0] instr_addr_out;
  logic [ROWS*HW-1:0] instr_hops_out;
  logic [ROWS-1:0]  instr_en_out;
  logic [ROWS-1:0]  call;
  logic [ROWS-1:0]  ret;
  logic             done_valid;
  logic             done_err;
  logic             busy;

  int checks = 0;
  int failures = 0;

  fabric_instr_dispatcher #(
    .ROWS(ROWS), .INSTR_ADDR_WIDTH(AW), .INSTR_DATA_WIDTH(DW),
    .INSTR_HOPS_WIDTH(HW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row),
    .cmd_hops(cmd_hops), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .instr_data_out(instr_data_out), .instr_addr_out(instr_addr_out),
    .instr_hops_out(instr_hops_out), .instr_en_out(instr_en_out),
    .call(call), .ret(ret), .done_valid(done_valid), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] row, input logic [AW-1:0] a,
                       input logic [HW-1:0] h, input logic [DW-1:0] d, input logic last);
    cmd_valid = 1'b1;
    cmd_row   = row;
    cmd_addr  = a;
    cmd_hops  = h;
    cmd_data  = d;
    cmd_last  = last;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_row = '0; cmd_hops = '0;
    cmd_addr = '0; cmd_data = '0; cmd_last = 1'b0; ret = 3'b111;
    tick(); tick();
    check("rst_en", 32'(instr_en_out), 32'h0);
    check("rst_call", 32'(call), 32'h0);
    check("rst_done", 32'(done_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data0", instr_data_out[31:0], 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(cmd_ready), 32'h1);

    // Three back-to-back words to row 0
    drive(2'd0, 6'd1, 4'd2, 32'hA1A1_0001, 1'b0); tick();
    check("t1_en_w0", 32'(instr_en_out), 32'h1);
    check("t1_data_w0", instr_data_out[31:0], 32'hA1A1_0001);
    drive(2'd0, 6'd2, 4'd3, 32'hA1A1_0002, 1'b0); tick();
    check("t1_en_w1", 32'(instr_en_out), 32'h1);
    check("t1_data_w1", instr_data_out[31:0], 32'hA1A1_0002);
    drive(2'd0, 6'd3, 4'd4, 32'hA1A1_0003, 1'b1); tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    check("t1_en_w2", 32'(instr_en_out), 32'h1);
    check("t1_addr_w2", 32'(instr_addr_out[5:0]), 32'd3);
    check("t1_hops_w2", 32'(instr_hops_out[3:0]), 32'd4);
    check("t1_call_early", 32'(call), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    tick();
    check("t1_call", 32'(call), 32'h1);
    check("t1_en_off", 32'(instr_en_out), 32'h0);
    tick();
    check("t1_call_off", 32'(call), 32'h0);
    ret = 3'b110;
    repeat (5) tick();
    check("t1_no_done_low", 32'(done_valid), 32'h0);
    ret = 3'b111;
    tick();
    check("t1_done", 32'(done_valid), 32'h1);
    check("t1_done_err", 32'(done_err), 32'h0);
    check("t1_data_hold", instr_data_out[31:0], 32'hA1A1_0003);
    tick();
    check("t1_done_off", 32'(done_valid), 32'h0);
    check("t1_ready", 32'(cmd_ready), 32'h1);

    // Rows 0 and 1, row 1 finishes late
    drive(2'd0, 6'd5, 4'd1, 32'hB0B0_0000, 1'b0); tick();
    check("t2_en_r0", 32'(instr_en_out), 32'h1);
    drive(2'd1, 6'd6, 4'd2, 32'hB1B1_0001, 1'b1); tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    check("t2_en_r1", 32'(instr_en_out), 32'h2);
    check("t2_data_r1", instr_data_out[63:32], 32'hB1B1_0001);
    check("t2_data_r0_hold", instr_data_out[31:0], 32'hB0B0_0000);
    check("t2_addr_r1", 32'(instr_addr_out[11:6]), 32'd6);
    tick();
    check("t2_call", 32'(call), 32'h3);
    ret = 3'b100;
    repeat (3) tick();
    ret = 3'b101;
    repeat (3) tick();
    check("t2_wait_r1", 32'(done_valid), 32'h0);
    ret = 3'b111;
    tick();
    check("t2_done", 32'(done_valid), 32'h1);
    check("t2_done_err", 32'(done_err), 32'h0);
    tick();

    // Out-of-range row as the only word
    drive(2'd3, 6'd7, 4'd7, 32'hDEAD_BEEF, 1'b1); tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    check("t3_no_en", 32'(instr_en_out), 32'h0);
    check("t3_no_call", 32'(call), 32'h0);
    check("t3_done", 32'(done_valid), 32'h1);
    check("t3_done_err", 32'(done_err), 32'h1);
    tick();
    check("t3_done_off", 32'(done_valid), 32'h0);
    check("t3_ready", 32'(cmd_ready), 32'h1);

    // cmd_valid held during WAIT
    drive(2'd2, 6'd8, 4'd5, 32'hC2C2_0002, 1'b1); tick();
    check("t4_en_r2", 32'(instr_en_out), 32'h4);
    drive(2'd0, 6'd9, 4'd6, 32'hC0C0_0000, 1'b0);
    check("t4_ready_low", 32'(cmd_ready), 32'h0);
    tick();
    check("t4_call", 32'(call), 32'h4);
    check("t4_en_blocked0", 32'(instr_en_out), 32'h0);
    ret = 3'b011;
    repeat (3) tick();
    check("t4_en_blocked1", 32'(instr_en_out), 32'h0);
    check("t4_ready_wait", 32'(cmd_ready), 32'h0);
    ret = 3'b111;
    tick();
    check("t4_done", 32'(done_valid), 32'h1);
    check("t4_en_blocked2", 32'(instr_en_out), 32'h0);
    tick();
    check("t4_ready_back", 32'(cmd_ready), 32'h1);
    check("t4_en_before_hs", 32'(instr_en_out), 32'h0);
    cmd_last = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    check("t4_en_held_word", 32'(instr_en_out), 32'h1);
    check("t4_data_held_word", instr_data_out[31:0], 32'hC0C0_0000);
    tick();
    check("t4_call2", 32'(call), 32'h1);
    ret = 3'b110;
    tick();
    ret = 3'b111;
    tick();
    check("t4_done2", 32'(done_valid), 32'h1);
    tick();

    // Async reset mid-WAIT
    drive(2'd1, 6'd10, 4'd9, 32'hE1E1_0001, 1'b1); tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    tick();
    check("t5_call", 32'(call), 32'h2);
    ret = 3'b101;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_call", 32'(call), 32'h0);
    check("t5_rst_data1", instr_data_out[63:32], 32'h0);
    check("t5_rst_ready", 32'(cmd_ready), 32'h1);
    ret = 3'b111;
    tick();
    rst_n = 1'b1;
    tick();
    drive(2'd0, 6'd11, 4'd1, 32'hF0F0_0000, 1'b1); tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    check("t5_en_after", 32'(instr_en_out), 32'h1);
    tick();
    check("t5_call_after", 32'(call), 32'h1);
    ret = 3'b110;
    tick();
    ret = 3'b111;
    tick();
    check("t5_done", 32'(done_valid), 32'h1);
    check("t5_done_err", 32'(done_err), 32'h0);
    tick();

`ifdef FABRIC_DISPATCH_TIMEOUT_EN
    // Row stuck busy: timeout after 16 WAIT cycles
    drive(2'd0, 6'd12, 4'd2, 32'h7070_0000, 1'b1); tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
    tick();
    check("t6_call", 32'(call), 32'h1);
    ret = 3'b110;
    repeat (15) tick();
    check("t6_not_yet", 32'(done_valid), 32'h0);
    tick();
    check("t6_done", 32'(done_valid), 32'h1);
    check("t6_done_err", 32'(done_err), 32'h1);
    ret = 3'b111;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
